rf_write_arbiter: RTL and testbench
===================================

// Module: rf_write_arbiter
// PURPOSE
//  Shares the register file's single write port between N_REQ result producers (ALU, load unit, ...).
//  Round-robin grant with valid/ready handshakes per requester.
//  Registered write port (1-cycle latency) with back-pressure from the register file.
//  Sits between the execute/memory stages and the register file write port.
// PARAMETERS
//  N_REQ   4          number of requesters (>=2)
//  n       BIT_WIDTH  data width in bits
//  ADDR_W  4          register address width
//  ZERO_R0 1          1: writes to address 0 are accepted and discarded (R0 hardwired zero)
// PORTS
//  clk        in   1             clock, rising edge
//  rst        in   1             reset, asynchronous, active-high
//  req_valid  in   N_REQ         requester i has a write pending
//  req_addr   in   N_REQ*ADDR_W  requester i target register, slice [i*ADDR_W +: ADDR_W]
//  req_data   in   N_REQ*n       requester i write data, slice [i*n +: n]
//  req_ready  out  N_REQ         requester i accepted this cycle (one-hot or zero)
//  rf_stall   in   1             register file cannot take the current write this cycle
//  rf_we      out  1             write enable to register file
//  rf_waddr   out  ADDR_W        write address
//  rf_wdata   out  n             write data
//  grant_id   out  clog2(N_REQ)  index of requester that produced current rf_we
// BEHAVIOUR
//  - Reset (async, while rst=1): rf_we=0, rf_waddr=0, rf_wdata=0, grant_id=0, rr pointer ptr=0.
//    Reset mid-operation drops any held write; no requester is acked.
//  - accept = !rf_we | !rf_stall (output register empty or draining this cycle).
//  - Pick: first i with req_valid[i]=1, searching ptr, ptr+1, ... wrapping mod N_REQ.
//  - req_ready[g]=1 iff accept and g is the pick; combinational from req_valid, ptr, rf_we, rf_stall.
//    All other req_ready bits 0. Handshake completes in the cycle valid&ready both high.
//  - Requesters hold valid/addr/data stable until ready; dropping valid before ready is permitted
//    (request withdrawn, no write).
//  - On clock edge with accept and a pick g:
//    rf_waddr<=addr[g], rf_wdata<=data[g], grant_id<=g, ptr<=(g+1) mod N_REQ,
//    rf_we<=1, except rf_we<=0 when ZERO_R0=1 and addr[g]==0.
//  - On edge with accept and no pick: rf_we<=0; addr/data/grant_id/ptr hold.
//  - On edge with !accept (rf_we=1 and rf_stall=1): all outputs and ptr hold; no ready asserted.
//  - rf_stall while rf_we=0 has no effect (accept stays 1).
//  - Latency: handshake in cycle t -> rf_we visible in cycle t+1; sustained throughput 1 write/cycle.
//  - Fairness: a continuously valid requester is granted within N_REQ accepting cycles.
//  - Two requesters targeting the same address: serviced in grant order; later grant wins in the RF.
// STRUCTURE
//  - BIT_WIDTH and the default register address width live in the shared constants header; the
//    RR_PTR_W = clog2(N_REQ) helper goes there too.
//  - Sub-module rr_pick: combinational round-robin picker (req vector + ptr -> found, index).
//  - Top holds ptr register, output register, accept logic, ready decode.
// TESTING
//  1 Reset: rst=1 async mid-cycle with rf_we=1 -> rf_we, rf_waddr, rf_wdata, grant_id all 0 at once.
//  2 Single: req_valid=0010, addr=5, data=0xA5 -> req_ready=0010 same cycle; next cycle rf_we=1,
//    rf_waddr=5, rf_wdata=0xA5, grant_id=1.
//  3 Round robin: req_valid=1111 held, rf_stall=0 -> grant_id sequence 0,1,2,3,0 on consecutive cycles.
//  4 Stall: rf_we=1 (addr 3) with rf_stall=1 for 3 cycles, req_valid=0001 -> req_ready=0 throughout,
//    outputs hold; stall drops -> req_ready[0]=1 same cycle, new write next cycle.
//  5 R0 discard: ZERO_R0=1, req addr=0 -> req_ready asserted, next cycle rf_we=0, ptr advanced.
//  6 Withdraw: requester 2 drops valid while stalled -> no write from 2, ptr unchanged.

Source files
------------

// File: rtl/rf_write_arbiter_pkg.sv
// Shared constants for the register-file write arbiter.
//   BIT_WIDTH      : default data width of a register-file write
//   DEFAULT_ADDR_W : default register address width
//   rr_ptr_w()     : width of a round-robin pointer / requester index
package rf_write_arbiter_pkg;

   localparam int BIT_WIDTH      = 16;
   localparam int DEFAULT_ADDR_W = 4;

   // clog2 with a floor of 1 so a pointer always has at least one bit.
   function automatic int rr_ptr_w(input int nreq);
      return (nreq > 1) ? $clog2(nreq) : 1;
   endfunction

endpackage

// File: rtl/rf_write_arbiter_if.sv
// Bundle between the result producers / register file and the write arbiter.
//   req_valid/req_addr/req_data : per-requester write requests (flattened slices)
//   req_ready                   : per-requester accept, one-hot or zero
//   rf_stall                    : register file back-pressure
//   rf_we/rf_waddr/rf_wdata     : registered register-file write port
//   grant_id                    : requester that produced the current write
// modport master : producer / register-file side
// modport slave  : arbiter side
interface rf_write_arbiter_if
   import rf_write_arbiter_pkg::*;
#(
   parameter int N_REQ  = 4,
   parameter int n      = BIT_WIDTH,
   parameter int ADDR_W = DEFAULT_ADDR_W
);
   localparam int PW = rr_ptr_w(N_REQ);

   logic [N_REQ-1:0]        req_valid;
   logic [N_REQ*ADDR_W-1:0] req_addr;
   logic [N_REQ*n-1:0]      req_data;
   logic [N_REQ-1:0]        req_ready;
   logic                    rf_stall;
   logic                    rf_we;
   logic [ADDR_W-1:0]       rf_waddr;
   logic [n-1:0]            rf_wdata;
   logic [PW-1:0]           grant_id;

   modport master (
      output req_valid, req_addr, req_data, rf_stall,
      input  req_ready, rf_we, rf_waddr, rf_wdata, grant_id
   );

   modport slave (
      input  req_valid, req_addr, req_data, rf_stall,
      output req_ready, rf_we, rf_waddr, rf_wdata, grant_id
   );
endinterface

// File: rtl/rf_write_arbiter_rr_pick.sv
// Combinational round-robin picker.
//   req   : request vector
//   ptr   : highest-priority index this cycle
//   found : at least one request is set
//   idx   : first set index searching ptr, ptr+1, ... wrapping mod N_REQ
module rr_pick
   import rf_write_arbiter_pkg::*;
#(
   parameter int N_REQ = 4,
   parameter int PW    = rr_ptr_w(N_REQ)
) (
   input  logic [N_REQ-1:0] req,
   input  logic [PW-1:0]    ptr,
   output logic             found,
   output logic [PW-1:0]    idx
);
   // Scan from the farthest offset down so the nearest set index to ptr
   // is the one left in idx.
   always_comb begin
      found = 1'b0;
      idx   = '0;
      for (int k = N_REQ - 1; k >= 0; k--) begin
         logic [PW-1:0] j;
         j = PW'((int'(ptr) + k) % N_REQ);
         if (req[j]) begin
            found = 1'b1;
            idx   = j;
         end
      end
   end
endmodule

// File: rtl/rf_write_arbiter.sv
// Shares the register file's single write port between N_REQ producers.
// Round-robin grant with per-requester valid/ready, registered write port
// (one-cycle latency) that holds while the register file stalls.
//   clk : clock, rising edge
//   rst : asynchronous active-high reset
//   bus : rf_write_arbiter_if.slave (requests, ready, rf write port, grant_id)
module rf_write_arbiter
   import rf_write_arbiter_pkg::*;
#(
   parameter int N_REQ   = 4,
   parameter int n       = BIT_WIDTH,
   parameter int ADDR_W  = DEFAULT_ADDR_W,
   parameter bit ZERO_R0 = 1'b1
) (
   input logic               clk,
   input logic               rst,
   rf_write_arbiter_if.slave bus
);
   localparam int PW = rr_ptr_w(N_REQ);

   logic [PW-1:0]     ptr;
   logic              we_q;
   logic [ADDR_W-1:0] waddr_q;
   logic [n-1:0]      wdata_q;
   logic [PW-1:0]     gid_q;

   logic              found;
   logic [PW-1:0]     pick;
   logic              accept;
   logic              take;
   logic [N_REQ-1:0]  ready;
   logic [ADDR_W-1:0] sel_addr;
   logic [n-1:0]      sel_data;

   rr_pick #(.N_REQ(N_REQ), .PW(PW)) u_pick (
      .req   (bus.req_valid),
      .ptr   (ptr),
      .found (found),
      .idx   (pick)
   );

   // Output register is empty, or its current write retires this cycle.
   assign accept = !we_q || !bus.rf_stall;
   assign take   = accept && found;

   always_comb begin
      ready = '0;
      if (take) ready[pick] = 1'b1;
   end

   assign sel_addr = bus.req_addr[int'(pick)*ADDR_W +: ADDR_W];
   assign sel_data = bus.req_data[int'(pick)*n +: n];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ptr     <= '0;
         we_q    <= 1'b0;
         waddr_q <= '0;
         wdata_q <= '0;
         gid_q   <= '0;
      end else if (accept) begin
         if (found) begin
            waddr_q <= sel_addr;
            wdata_q <= sel_data;
            gid_q   <= pick;
            ptr     <= (pick == PW'(N_REQ - 1)) ? '0 : pick + 1'b1;
            // R0 writes complete the handshake but never reach the file.
            we_q    <= !(ZERO_R0 && (sel_addr == '0));
         end else begin
            we_q    <= 1'b0;
         end
      end
   end

   assign bus.req_ready = ready;
   assign bus.rf_we     = we_q;
   assign bus.rf_waddr  = waddr_q;
   assign bus.rf_wdata  = wdata_q;
   assign bus.grant_id  = gid_q;
endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed, table-driven bench for rf_write_arbiter (N_REQ=4, 16-bit data,
// 4-bit addresses, R0 discard on). Each table row is applied for one cycle:
// req_ready is checked mid-cycle, the registered port just after the edge.
module tb_rf_write_arbiter;
   localparam int N  = 4;
   localparam int W  = 16;
   localparam int AW = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   rf_write_arbiter_if #(.N_REQ(N), .n(W), .ADDR_W(AW)) bus ();

   rf_write_arbiter #(.N_REQ(N), .n(W), .ADDR_W(AW), .ZERO_R0(1'b1)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   typedef struct {
      logic [N-1:0]    valid;
      logic [N*AW-1:0] addr;
      logic [N*W-1:0]  data;
      logic            stall;
      logic [N-1:0]    e_ready;
      logic            e_we;
      logic [AW-1:0]   e_waddr;
      logic [W-1:0]    e_wdata;
      logic [1:0]      e_gid;
   } vec_t;

   // Requester i: addr 3/5/7/9, data B0/A5/C2/D3.
   localparam logic [N*AW-1:0] ADDRS = {4'd9, 4'd7, 4'd5, 4'd3};
   localparam logic [N*W-1:0]  DATAS = {16'h00D3, 16'h00C2, 16'h00A5, 16'h00B0};

   int checks   = 0;
   int failures = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic [N-1:0] v, input logic s, input logic [N-1:0] er,
                               input logic ew, input logic [AW-1:0] ea,
                               input logic [W-1:0] ed, input logic [1:0] eg);
      vec_t r;
      r.valid = v;  r.addr = ADDRS; r.data = DATAS; r.stall = s;
      r.e_ready = er; r.e_we = ew; r.e_waddr = ea; r.e_wdata = ed; r.e_gid = eg;
      return r;
   endfunction

   task automatic chk_out(input string tag, input logic ew, input logic [AW-1:0] ea,
                          input logic [W-1:0] ed, input logic [1:0] eg);
      chk({tag, " rf_we"},    32'(bus.rf_we),    32'(ew));
      chk({tag, " rf_waddr"}, 32'(bus.rf_waddr), 32'(ea));
      chk({tag, " rf_wdata"}, 32'(bus.rf_wdata), 32'(ed));
      chk({tag, " grant_id"}, 32'(bus.grant_id), 32'(eg));
   endtask

   vec_t tbl[17];

   initial begin
      // Round robin from reset pointer 0.
      tbl[0]  = mk(4'b1111, 0, 4'b0001, 1, 3, 16'h00B0, 0);
      tbl[1]  = mk(4'b1111, 0, 4'b0010, 1, 5, 16'h00A5, 1);
      tbl[2]  = mk(4'b1111, 0, 4'b0100, 1, 7, 16'h00C2, 2);
      tbl[3]  = mk(4'b1111, 0, 4'b1000, 1, 9, 16'h00D3, 3);
      tbl[4]  = mk(4'b1111, 0, 4'b0001, 1, 3, 16'h00B0, 0);
      // Idle: we drops, fields hold.
      tbl[5]  = mk(4'b0000, 0, 4'b0000, 0, 3, 16'h00B0, 0);
      // Single request from 1 (addr 5, data A5).
      tbl[6]  = mk(4'b0010, 0, 4'b0010, 1, 5, 16'h00A5, 1);
      // Three stalled cycles: no ready, outputs hold; requester 2 withdraws.
      tbl[7]  = mk(4'b0001, 1, 4'b0000, 1, 5, 16'h00A5, 1);
      tbl[8]  = mk(4'b0100, 1, 4'b0000, 1, 5, 16'h00A5, 1);
      tbl[9]  = mk(4'b0000, 1, 4'b0000, 1, 5, 16'h00A5, 1);
      // Stall released with nothing pending: write drains.
      tbl[10] = mk(4'b0000, 0, 4'b0000, 0, 5, 16'h00A5, 1);
      // Stall with we=0 is ignored; ptr still 2 so 3 beats 0.
      tbl[11] = mk(4'b1001, 1, 4'b1000, 1, 9, 16'h00D3, 3);
      // R0 discard: acked, no write, ptr advances to 1.
      tbl[12] = mk(4'b0001, 0, 4'b0001, 0, 0, 16'h0077, 0);
      tbl[12].addr = {4'd9, 4'd7, 4'd5, 4'd0};
      tbl[12].data = {16'h00D3, 16'h00C2, 16'h00A5, 16'h0077};
      tbl[13] = mk(4'b1111, 0, 4'b0010, 1, 5, 16'h00A5, 1);
      // Stall then release: ready for 0 in the release cycle.
      tbl[14] = mk(4'b0001, 1, 4'b0000, 1, 5, 16'h00A5, 1);
      tbl[15] = mk(4'b0001, 0, 4'b0001, 1, 3, 16'h00B0, 0);
      tbl[16] = mk(4'b0001, 0, 4'b0001, 1, 3, 16'h00B0, 0);

      bus.req_valid = '0;
      bus.req_addr  = ADDRS;
      bus.req_data  = DATAS;
      bus.rf_stall  = 1'b0;

      #1;
      chk_out("reset", 0, 0, 16'h0, 0);
      @(posedge clk); #1;
      rst = 1'b0;

      for (int i = 0; i < 17; i++) begin
         bus.req_valid = tbl[i].valid;
         bus.req_addr  = tbl[i].addr;
         bus.req_data  = tbl[i].data;
         bus.rf_stall  = tbl[i].stall;
         #3;
         chk($sformatf("v%0d req_ready", i), 32'(bus.req_ready), 32'(tbl[i].e_ready));
         @(posedge clk); #1;
         chk_out($sformatf("v%0d", i), tbl[i].e_we, tbl[i].e_waddr, tbl[i].e_wdata, tbl[i].e_gid);
      end

      // Async reset mid-cycle while a write is held: clears at once.
      bus.rf_stall = 1'b1;
      #3;
      rst = 1'b1;
      #1;
      chk_out("async_rst", 0, 0, 16'h0, 0);
      @(posedge clk); #1;
      rst = 1'b0;
      chk_out("post_rst", 0, 0, 16'h0, 0);

      // Pointer was 1 before reset; after reset requester 0 must win.
      bus.req_valid = 4'b1111;
      bus.req_addr  = ADDRS;
      bus.req_data  = DATAS;
      bus.rf_stall  = 1'b0;
      #3;
      chk("rst_ptr req_ready", 32'(bus.req_ready), 32'h1);
      @(posedge clk); #1;
      chk_out("rst_ptr", 1, 3, 16'h00B0, 0);
      bus.req_valid = '0;
      @(posedge clk); #1;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
